// File: rtl/otter_input_port.sv
// MMIO input port: synchronized switches, debounced buttons and a clear-on-read press-event register.
// Optional feature macro: INPUT_PORT_IRQ_EN enables the event register and the intr output.
module otter_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] SW_ADDR         = 32'h1100_0000,
  parameter logic [31:0] BTN_ADDR        = 32'h1100_0004,
  parameter logic [31:0] EVT_ADDR        = 32'h1100_0008
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  buttons,
  input  logic [15:0] switches,
  input  logic        io_rd,
  input  logic [31:0] io_addr,
  output logic [31:0] io_rdata,
  output logic        io_rvalid,
  output logic        intr
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [4:0]    btn_meta;
  logic [4:0]    btn_sync;
  logic [15:0]   sw_meta;
  logic [15:0]   sw_sync;
  logic [4:0]    btn_stable;
  logic [CW-1:0] cnt [5];
  logic [4:0]    btn_diff;
  logic [4:0]    btn_flip;
  logic [31:0]   evt_word;
  logic [31:0]   rd_mux;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= buttons;
      btn_sync <= btn_meta;
      sw_meta  <= switches;
      sw_sync  <= sw_meta;
    end
  end

  // A button flips when it has disagreed with its stable value for DEBOUNCE_CYCLES cycles.
  always_comb begin
    btn_diff = btn_sync ^ btn_stable;
    btn_flip = '0;
    for (int i = 0; i < 5; i++) begin
      btn_flip[i] = btn_diff[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_stable <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      btn_stable <= btn_stable ^ btn_flip;
      for (int i = 0; i < 5; i++) begin
        if (!btn_diff[i] || btn_flip[i]) cnt[i] <= '0;
        else                             cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

`ifdef INPUT_PORT_IRQ_EN
  logic [4:0] evt;
  logic [4:0] evt_clr;
  logic [4:0] btn_rise;

  // Rising edges are taken from the flip itself so evt sets on the same edge as btn_stable.
  always_comb begin
    btn_rise = btn_flip & btn_sync;
    evt_clr  = (io_rd && (io_addr == EVT_ADDR)) ? evt : 5'b0;
    evt_word = {27'b0, evt};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt  <= '0;
      intr <= 1'b0;
    end else begin
      evt  <= (evt & ~evt_clr) | btn_rise;
      intr <= |evt;
    end
  end
`else
  assign evt_word = 32'b0;
  assign intr     = 1'b0;
`endif

  always_comb begin
    rd_mux = 32'b0;
    if (io_addr == SW_ADDR)       rd_mux = {16'b0, sw_sync};
    else if (io_addr == BTN_ADDR) rd_mux = {27'b0, btn_stable};
    else if (io_addr == EVT_ADDR) rd_mux = evt_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io_rdata  <= '0;
      io_rvalid <= 1'b0;
    end else begin
      io_rvalid <= io_rd;
      if (io_rd) io_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_otter_input_port.sv
// Directed bench for otter_input_port with DEBOUNCE_CYCLES=16.
module tb_otter_input_port;
  localparam logic [31:0] SW_A  = 32'h1100_0000;
  localparam logic [31:0] BTN_A = 32'h1100_0004;
  localparam logic [31:0] EVT_A = 32'h1100_0008;
`ifdef INPUT_PORT_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  buttons = '0;
  logic [15:0] switches = '0;
  logic        io_rd = 1'b0;
  logic [31:0] io_addr = '0;
  logic [31:0] io_rdata;
  logic        io_rvalid;
  logic        intr;

  int total = 0;
  int bad = 0;

  otter_input_port #(.DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .switches(switches),
    .io_rd(io_rd), .io_addr(io_addr), .io_rdata(io_rdata),
    .io_rvalid(io_rvalid), .intr(intr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] sw;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v);
    io_rd = 1'b1;
    io_addr = a;
    tick(1);
    io_rd = 1'b0;
    d = io_rdata;
    v = io_rvalid;
  endtask

  initial begin
    logic [31:0] d;
    logic v;

    tbl[0] = '{SW_A,          16'hA5C3, 32'h0000_A5C3};
    tbl[1] = '{SW_A,          16'hFFFF, 32'h0000_FFFF};
    tbl[2] = '{SW_A,          16'h0001, 32'h0000_0001};
    tbl[3] = '{BTN_A,         16'h0001, 32'h0000_0000};
    tbl[4] = '{32'h1100_000C, 16'h0001, 32'h0000_0000};
    tbl[5] = '{32'h0000_0000, 16'h8000, 32'h0000_0000};
    tbl[6] = '{EVT_A,         16'h8000, 32'h0000_0000};
    tbl[7] = '{SW_A,          16'h1234, 32'h0000_1234};

    // reset state
    tick(3);
    chk("rst_rdata", io_rdata, 32'h0);
    chk("rst_rvalid", {31'b0, io_rvalid}, 32'h0);
    chk("rst_intr", {31'b0, intr}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 8; i++) begin
      switches = tbl[i].sw;
      tick(2);
      rd(tbl[i].addr, d, v);
      chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp);
      chk($sformatf("tbl%0d_rvalid", i), {31'b0, v}, 32'h1);
      tick(1);
      chk($sformatf("tbl%0d_rvalid_drop", i), {31'b0, io_rvalid}, 32'h0);
      chk($sformatf("tbl%0d_hold", i), io_rdata, tbl[i].exp);
    end

    // back-to-back reads
    io_rd = 1'b1;
    io_addr = SW_A;
    tick(1);
    chk("b2b_v0", {31'b0, io_rvalid}, 32'h1);
    chk("b2b_d0", io_rdata, 32'h0000_1234);
    io_addr = BTN_A;
    tick(1);
    io_rd = 1'b0;
    chk("b2b_v1", {31'b0, io_rvalid}, 32'h1);
    chk("b2b_d1", io_rdata, 32'h0);
    tick(1);
    chk("b2b_v2", {31'b0, io_rvalid}, 32'h0);

    // clean press of button 0
    buttons[0] = 1'b1;
    tick(17);
    chk("b0_e17", {27'b0, dut.btn_stable}, 32'h0);
    tick(1);
    chk("b0_e18", {27'b0, dut.btn_stable}, 32'h1);
    chk("b0_intr_e18", {31'b0, intr}, 32'h0);
    tick(1);
    chk("b0_intr_e19", {31'b0, intr}, {31'b0, IRQ});
    rd(BTN_A, d, v);
    chk("b0_btn_read", d, 32'h1);

    // evt = 00011, then a read on the same edge button 4 sets
    buttons[1] = 1'b1;
    tick(20);
    buttons[4] = 1'b1;
    tick(17);
    io_rd = 1'b1;
    io_addr = EVT_A;
    tick(1);
    io_rd = 1'b0;
    chk("evt_clr_rdata", io_rdata, IRQ ? 32'h3 : 32'h0);
    chk("evt_clr_rvalid", {31'b0, io_rvalid}, 32'h1);
    chk("b4_e18", {27'b0, dut.btn_stable}, 32'h13);
    rd(EVT_A, d, v);
    chk("evt_setwins", d, IRQ ? 32'h10 : 32'h0);
    chk("evt_setwins_intr", {31'b0, intr}, {31'b0, IRQ});
    tick(1);
    chk("intr_fall", {31'b0, intr}, 32'h0);

    // bouncing button 2
    for (int k = 0; k < 8; k++) begin
      buttons[2] = ~buttons[2];
      tick(5);
    end
    chk("b2_bounce", {31'b0, dut.btn_stable[2]}, 32'h0);
    buttons[2] = 1'b1;
    tick(17);
    chk("b2_e17", {31'b0, dut.btn_stable[2]}, 32'h0);
    tick(1);
    chk("b2_e18", {31'b0, dut.btn_stable[2]}, 32'h1);
    rd(EVT_A, d, v);
    chk("b2_evt", d, IRQ ? 32'h4 : 32'h0);
    rd(EVT_A, d, v);
    chk("b2_evt_once", d, 32'h0);

    // releases do not create events
    buttons = '0;
    tick(20);
    chk("rel_stable", {27'b0, dut.btn_stable}, 32'h0);
    rd(EVT_A, d, v);
    chk("rel_evt", d, 32'h0);
    tick(1);
    chk("rel_intr", {31'b0, intr}, 32'h0);

    // reset mid-debounce, coincident with a read
    rd(SW_A, d, v);
    chk("pre_rst_sw", d, 32'h0000_1234);
    buttons[1] = 1'b1;
    tick(10);
    rst_n = 1'b0;
    io_rd = 1'b1;
    io_addr = SW_A;
    tick(1);
    rst_n = 1'b1;
    io_rd = 1'b0;
    chk("mid_rst_rdata", io_rdata, 32'h0);
    chk("mid_rst_rvalid", {31'b0, io_rvalid}, 32'h0);
    chk("mid_rst_stable", {27'b0, dut.btn_stable}, 32'h0);
    tick(17);
    chk("b1_rst_e17", {27'b0, dut.btn_stable}, 32'h0);
    tick(1);
    chk("b1_rst_e18", {27'b0, dut.btn_stable}, 32'h2);
    tick(1);
    chk("b1_rst_intr", {31'b0, intr}, {31'b0, IRQ});
    rd(EVT_A, d, v);
    chk("b1_rst_evt", d, IRQ ? 32'h2 : 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/otter_input_port.md
OTTER_INPUT_PORT -- requirements
Module: otter_input_port

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive cycles a synchronized button must differ from its stable value before the stable value updates; legal range 2..2^20.
REQ-002 Parameter SW_ADDR, default 32'h1100_0000, switch register address.
REQ-003 Parameter BTN_ADDR, default 32'h1100_0004, debounced button register address.
REQ-004 Parameter EVT_ADDR, default 32'h1100_0008, button-press event register address (clear-on-read).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 buttons  input  5  raw asynchronous push-buttons.
REQ-008 switches  input  16  raw asynchronous slide switches.
REQ-009 io_rd  input  1  CPU MMIO read strobe, one cycle per read.
REQ-010 io_addr  input  32  CPU MMIO read address, valid with io_rd.
REQ-011 io_rdata  output  32  read data.
REQ-012 io_rvalid  output  1  read-data-valid pulse.
REQ-013 intr  output  1  level interrupt request to the CPU.

Function
REQ-014 Each buttons and switches bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Per button, a debounce counter of width clog2(DEBOUNCE_CYCLES) SHALL increment each cycle the synchronized bit differs from btn_stable and SHALL clear when they are equal.
REQ-016 When the counter equals DEBOUNCE_CYCLES-1 and the bit still differs, btn_stable SHALL take the synchronized value on that edge and the counter SHALL clear; the counter never wraps.
REQ-017 A clean input step SHALL appear on btn_stable exactly 2+DEBOUNCE_CYCLES rising edges after the first edge sampling the new level; any bounce restarts the count.
REQ-018 Switches SHALL NOT be debounced; the switch register is the synchronizer output (2-edge latency).
REQ-019 A 0->1 transition of btn_stable[i] SHALL set evt[i]; 1->0 transitions SHALL NOT affect evt.
REQ-020 Reads SHALL have 1-cycle latency: on the edge where io_rd=1, io_rdata is loaded and io_rvalid asserts for exactly one cycle; io_rdata holds its value until the next read.
REQ-021 Read map: SW_ADDR -> {16'b0, switches_sync}; BTN_ADDR -> {27'b0, btn_stable}; EVT_ADDR -> {27'b0, evt}; any other address -> 32'b0 with io_rvalid still asserted.
REQ-022 A read of EVT_ADDR SHALL clear exactly the evt bits returned; a press edge arriving on the same edge SHALL set its bit (set wins over clear).
REQ-023 Back-to-back io_rd on consecutive cycles SHALL each be serviced with io_rvalid high on each following cycle.
REQ-024 intr SHALL equal the OR of all evt bits, registered (1 edge after evt changes).

Reset
REQ-025 While rst_n=0 at a rising edge: synchronizers, counters, btn_stable, evt, io_rdata, io_rvalid and intr SHALL all become 0.
REQ-026 A button held during reset SHALL be treated as a new 0->1 edge after reset release, setting evt once after the full debounce delay.
REQ-027 Reset asserted mid-debounce or coincident with io_rd SHALL discard the count and the read (no io_rvalid).

Configuration
REQ-028 Macro INPUT_PORT_IRQ_EN defined: evt register, clear-on-read and intr behave per REQ-019, REQ-022, REQ-024.
REQ-029 Macro INPUT_PORT_IRQ_EN undefined: no evt storage; EVT_ADDR reads return 32'b0 with io_rvalid; intr tied 0; port list unchanged.

Verification (DEBOUNCE_CYCLES=16, INPUT_PORT_IRQ_EN defined)
REQ-030 switches=16'hA5C3 after reset, read SW_ADDR 2 cycles later -> io_rdata=32'h0000_A5C3, io_rvalid high 1 cycle after io_rd.
REQ-031 buttons[0] 0->1 clean -> btn_stable[0] rises on edge 18, evt=5'b00001 on same edge, intr=1 one edge later; read BTN_ADDR -> 32'h1.
REQ-032 buttons[2] toggled every 5 cycles for 40 cycles then held 1 -> btn_stable[2] rises exactly 18 edges after final toggle, evt[2] set once.
REQ-033 evt=5'b00011, read EVT_ADDR -> io_rdata=32'h3, evt=0, intr falls one edge later; read issued on same edge evt[4] sets -> returns 32'h3, evt=5'b10000 afterward.
REQ-034 rst_n=0 for 1 cycle at count 10 of a buttons[1] press, input held -> all outputs 0, btn_stable[1] rises 18 edges after rst_n release.
REQ-035 Read io_addr=32'h1100_000C -> io_rdata=0, io_rvalid=1; same bench with macro undefined: press buttons[0], read EVT_ADDR -> 0, intr stays 0.
